// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic-array front end.
//   mat8_t        : 4x4 matrix of 8-bit operands, indexed [row][col]
//   mat16_t       : 4x4 matrix of 16-bit results, indexed [row][col]
//   state_t       : arbiter FSM states
//   ARRAY_LATENCY : nominal cycles from start pulse to result strobe
package systolic_array_pkg;

  localparam int ARRAY_LATENCY = 11;

  typedef logic [3:0][3:0][7:0]  mat8_t;
  typedef logic [3:0][3:0][15:0] mat16_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : encoded grant index (zero when no request)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest candidate back to ptr+1 so the nearest
  // requester after the pointer is the last (and winning) write.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        gnt_idx = cand;
      end
    end
  end

  assign gnt = (|req) ? (N_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/systolic_array_arbiter.sv
// Shares one 4x4 systolic-array multiplier between N_REQ requesters.
// Round-robin accepts a job, issues a one-cycle start pulse with the
// captured operands, waits for the result under a watchdog and returns
// C with the requester id over a valid/ready channel.
//   i_clk, i_arst              : clock, async active-high reset
//   i_reqValid/o_reqReady      : per-requester handshake (ready is one-hot)
//   i_reqA, i_reqB             : per-requester operand matrices
//   o_rspValid/i_rspReady      : response handshake
//   o_rspC, o_rspId            : result matrix and owning requester
//   o_rspTimeout               : job abandoned by the watchdog, o_rspC is zero
//   o_saA, o_saB, o_saValidInput : operands and start pulse to the array
//   i_saC, i_saValidResult     : array result and its strobe
//   o_busy                     : a job is in flight
module systolic_array_arbiter
  import systolic_array_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 31,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [N_REQ-1:0]       i_reqValid,
  output logic [N_REQ-1:0]       o_reqReady,
  input  mat8_t [N_REQ-1:0]      i_reqA,
  input  mat8_t [N_REQ-1:0]      i_reqB,
  output logic                   o_rspValid,
  input  logic                   i_rspReady,
  output mat16_t                 o_rspC,
  output logic [ID_W-1:0]        o_rspId,
  output logic                   o_rspTimeout,
  output mat8_t                  o_saA,
  output mat8_t                  o_saB,
  output logic                   o_saValidInput,
  input  mat16_t                 i_saC,
  input  logic                   i_saValidResult,
  output logic                   o_busy
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  if (TIMEOUT <= ARRAY_LATENCY) begin : g_bad_timeout
    $error("TIMEOUT must exceed the array latency");
  end

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  mat8_t             a_q;
  mat8_t             b_q;
  mat16_t            c_q;
  logic              tmo_q;
  logic              sa_valid_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic [WD_W-1:0]   wd;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (i_reqValid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state       <= IDLE;
      ptr         <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      tmo_q       <= 1'b0;
      sa_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wd          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_reqValid) begin
            a_q        <= i_reqA[gnt_idx];
            b_q        <= i_reqB[gnt_idx];
            id_q       <= gnt_idx;
            sa_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          sa_valid_q <= 1'b0;
          wd         <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // A result arriving on the expiry cycle still wins.
          if (i_saValidResult) begin
            c_q         <= i_saC;
            tmo_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (wd == WD_LAST) begin
            c_q         <= '0;
            tmo_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (i_rspReady) begin
            ptr         <= id_q;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_reqReady     = (state == IDLE) ? gnt : '0;
  assign o_saA          = a_q;
  assign o_saB          = b_q;
  assign o_saValidInput = sa_valid_q;
  assign o_rspValid     = rsp_valid_q;
  assign o_rspC         = c_q;
  assign o_rspId        = id_q;
  assign o_rspTimeout   = tmo_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_systolic_array_arbiter.sv
module tb_systolic_array_arbiter;
  import systolic_array_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 31;
  localparam int ID_W    = 2;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [N_REQ-1:0]  req_ready;
  mat8_t [N_REQ-1:0] req_a = '0;
  mat8_t [N_REQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  mat16_t            rsp_c;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_timeout;
  mat8_t             sa_a;
  mat8_t             sa_b;
  logic              sa_valid_input;
  mat16_t            sa_c;
  logic              sa_valid_result;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // array model state
  int     model_lat = 11;
  int     rem       = 0;
  logic   model_v   = 1'b0;
  mat16_t model_c   = '0;
  mat16_t model_res = '0;
  logic   stray_v   = 1'b0;
  mat16_t stray_c   = '1;

  mat8_t  ident, b0, abp, bbp;
  mat16_t exp_b0, exp_bp;
  int     g, t0;
  bit     ok;

  systolic_array_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .ID_W    (ID_W)
  ) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_reqValid      (req_valid),
    .o_reqReady      (req_ready),
    .i_reqA          (req_a),
    .i_reqB          (req_b),
    .o_rspValid      (rsp_valid),
    .i_rspReady      (rsp_ready),
    .o_rspC          (rsp_c),
    .o_rspId         (rsp_id),
    .o_rspTimeout    (rsp_timeout),
    .o_saA           (sa_a),
    .o_saB           (sa_b),
    .o_saValidInput  (sa_valid_input),
    .i_saC           (sa_c),
    .i_saValidResult (sa_valid_result),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic mat16_t mat_mul(mat8_t a, mat8_t b);
    mat16_t c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          c[i][j] = c[i][j] + 16'(a[i][k]) * 16'(b[k][j]);
    return c;
  endfunction

  // Array model: result strobe model_lat cycles after the start pulse
  // (model_lat == 0 means the array never answers).
  always @(negedge clk or posedge arst) begin
    if (arst) begin
      rem     = 0;
      model_v = 1'b0;
    end else begin
      model_v = 1'b0;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          model_v = 1'b1;
          model_c = model_res;
        end
      end
      if (sa_valid_input && model_lat > 0) begin
        rem       = model_lat;
        model_res = mat_mul(sa_a, sa_b);
      end
    end
  end

  assign sa_valid_result = model_v | stray_v;
  assign sa_c            = model_v ? model_c : stray_c;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(output int idx, output bit found);
    found = 1'b0;
    idx   = -1;
    #1;
    for (int n = 0; n < 60; n++) begin
      if (req_ready != '0) begin
        found = 1'b1;
        for (int b = 0; b < N_REQ; b++) if (req_ready[b]) idx = b;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit found);
    found = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (!busy) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (sa_valid_input !== 1'b0) begin n_fail++; $display("FAIL reset_sa_valid: got %b expected 0", sa_valid_input); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_timeout: got %b expected 0", rsp_timeout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (sa_a !== '0) begin n_fail++; $display("FAIL reset_sa_a: got %h expected 0", sa_a); end
    n_checks++; if (rsp_c !== '0) begin n_fail++; $display("FAIL reset_rsp_c: got %h expected 0", rsp_c); end
    tick();
    arst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    req_a[0]  = ident;
    req_b[0]  = b0;
    req_valid = 4'b0001;
    wait_accept(g, ok);
    n_checks++; if (!ok || g !== 0) begin n_fail++; $display("FAIL single_accept: got idx %0d ok %0d expected idx 0", g, ok); end
    t0 = cyc;
    n_checks++; if (sa_valid_input !== 1'b0) begin n_fail++; $display("FAIL single_no_early_start: got %b expected 0", sa_valid_input); end
    tick();
    req_valid = '0;
    n_checks++; if (sa_valid_input !== 1'b1) begin n_fail++; $display("FAIL single_start_pulse: got %b expected 1", sa_valid_input); end
    n_checks++; if (sa_a !== ident || sa_b !== b0) begin n_fail++; $display("FAIL single_operands: got %h/%h expected %h/%h", sa_a, sa_b, ident, b0); end
    for (int k = 2; k <= 12; k++) begin
      tick();
      n_checks++;
      if ({sa_valid_input, rsp_valid} !== 2'b00) begin
        n_fail++; $display("FAIL single_quiet_T+%0d: got start/valid %b expected 00", k, {sa_valid_input, rsp_valid});
      end
    end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid_T+13: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_c !== exp_b0) begin n_fail++; $display("FAIL single_rsp_c: got %h expected %h", rsp_c, exp_b0); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_rsp_timeout: got %b expected 0", rsp_timeout); end
    tick();
    n_checks++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy/valid %b expected 00", {busy, rsp_valid}); end
  endtask

  task automatic test_stray_idle();
    tick();
    stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    tick();
    n_checks++; if ({busy, rsp_valid, sa_valid_input} !== 3'b000) begin n_fail++; $display("FAIL stray_idle_state: got busy/valid/start %b expected 000", {busy, rsp_valid, sa_valid_input}); end
    n_checks++; if (rsp_c !== exp_b0) begin n_fail++; $display("FAIL stray_idle_rsp_c: got %h expected %h", rsp_c, exp_b0); end
  endtask

  task automatic test_round_robin();
    int gi[5];
    int gt[5];
    int ng;
    ng = 0;
    tick();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      req_a[r] = ident;
      req_b[r] = b0;
    end
    req_valid = '1;
    #1;
    for (int n = 0; n < 90 && ng < 5; n++) begin
      if (n > 0) tick();
      n_checks++;
      if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL rr_onehot: got %b expected at most one bit", req_ready); end
      if (req_ready != '0) begin
        for (int b = 0; b < N_REQ; b++) if (req_ready[b]) gi[ng] = b;
        gt[ng] = cyc;
        ng++;
      end
    end
    tick();
    req_valid = '0;
    n_checks++; if (ng !== 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", ng); end
    for (int k = 0; k < ng; k++) begin
      n_checks++; if (gi[k] !== k % 4) begin n_fail++; $display("FAIL rr_order_%0d: got %0d expected %0d", k, gi[k], k % 4); end
      if (k > 0) begin
        n_checks++; if (gt[k] - gt[k-1] !== 14) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected 14", k, gt[k] - gt[k-1]); end
      end
    end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_drain: got busy expected idle"); end
  endtask

  task automatic test_backpressure();
    tick();
    req_a[0]  = abp;
    req_b[0]  = bbp;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    wait_accept(g, ok);
    n_checks++; if (!ok || g !== 0) begin n_fail++; $display("FAIL bp_accept: got idx %0d expected 0", g); end
    t0 = cyc;
    tick();
    req_valid = 4'b0010;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++; if (!ok || cyc - t0 !== 13) begin n_fail++; $display("FAIL bp_rsp_latency: got %0d ok %0d expected 13", cyc - t0, ok); end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      stray_v = (k == 3);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", k, rsp_valid); end
      n_checks++; if (rsp_c !== exp_bp) begin n_fail++; $display("FAIL bp_hold_c_%0d: got %h expected %h", k, rsp_c, exp_bp); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold_id_%0d: got %0d expected 0", k, rsp_id); end
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_no_accept_%0d: got %b expected 0", k, req_ready); end
    end
    stray_v   = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_handshake_cycle: got %b expected 0", req_ready); end
    tick();
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_req1_accept: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain: got busy expected idle"); end
  endtask

  task automatic test_timeout();
    model_lat = 0;
    tick();
    req_a[2]  = ident;
    req_b[2]  = b0;
    req_valid = 4'b0100;
    wait_accept(g, ok);
    n_checks++; if (!ok || g !== 2) begin n_fail++; $display("FAIL to_accept: got idx %0d expected 2", g); end
    tick();
    req_valid = '0;
    for (int k = 2; k <= 33; k++) begin
      tick();
      if (k == 32) begin
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early_valid: got %b expected 0", rsp_valid); end
      end
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", rsp_timeout); end
    n_checks++; if (rsp_c !== '0) begin n_fail++; $display("FAIL to_rsp_c: got %h expected 0", rsp_c); end
    n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL to_rsp_id: got %0d expected 2", rsp_id); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_drain: got busy expected idle"); end
  endtask

  task automatic test_simultaneous();
    model_lat = 31;
    tick();
    req_a[3]  = abp;
    req_b[3]  = bbp;
    req_valid = 4'b1000;
    wait_accept(g, ok);
    n_checks++; if (!ok || g !== 3) begin n_fail++; $display("FAIL sim_accept: got idx %0d expected 3", g); end
    tick();
    req_valid = '0;
    for (int k = 2; k <= 33; k++) begin
      tick();
      if (k == 32) begin
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_early_valid: got %b expected 0", rsp_valid); end
      end
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sim_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL sim_flag: got %b expected 0", rsp_timeout); end
    n_checks++; if (rsp_c !== exp_bp) begin n_fail++; $display("FAIL sim_rsp_c: got %h expected %h", rsp_c, exp_bp); end
    n_checks++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL sim_rsp_id: got %0d expected 3", rsp_id); end
    model_lat = 11;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_drain: got busy expected idle"); end
  endtask

  task automatic test_reset_mid();
    tick();
    req_a[1]  = abp;
    req_b[1]  = bbp;
    req_valid = 4'b0010;
    wait_accept(g, ok);
    n_checks++; if (!ok || g !== 1) begin n_fail++; $display("FAIL rm_accept: got idx %0d expected 1", g); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_in_wait: got %b expected 1", busy); end
    arst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_checks++; if (sa_a !== '0 || sa_b !== '0) begin n_fail++; $display("FAIL rm_operands: got %h/%h expected 0", sa_a, sa_b); end
    n_checks++; if (rsp_c !== '0) begin n_fail++; $display("FAIL rm_rsp_c: got %h expected 0", rsp_c); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rm_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if ({rsp_valid, rsp_timeout, sa_valid_input} !== 3'b000) begin n_fail++; $display("FAIL rm_flags: got %b expected 000", {rsp_valid, rsp_timeout, sa_valid_input}); end
    tick();
    arst      = 1'b0;
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr_reset: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  initial begin
    ident = '0;
    for (int i = 0; i < 4; i++) begin
      ident[i][i] = 8'd1;
      for (int j = 0; j < 4; j++) begin
        b0[i][j]     = 8'(i * 4 + j);
        exp_b0[i][j] = 16'(i * 4 + j);
        abp[i][j]    = 8'(i + j + 1);
        bbp[i][j]    = (i == j) ? 8'd200 : 8'(j + 3);
      end
    end
    exp_bp = mat_mul(abp, bbp);

    test_reset();
    test_single();
    test_stray_idle();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
